// File: rtl/pathfinder_pkg.sv
// ---------------------------------------------------------------------------
// pathfinder_pkg: shared FSM state type and saturating arithmetic helpers.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pathfinder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EVAL   = 2'd2,
    ST_STEP   = 2'd3
  } state_e;

  // Result is {clamped, value}; the extra bit catches overflow before clamping.
  function automatic logic [32:0] sat_add(input logic [31:0] val,
                                          input logic [31:0] step,
                                          input logic [31:0] hi);
    logic [32:0] sum;
    sum = {1'b0, val} + {1'b0, step};
    if (sum > {1'b0, hi}) begin
      return {1'b1, hi};
    end
    return sum;
  endfunction

  function automatic logic [32:0] sat_sub(input logic [31:0] val,
                                          input logic [31:0] step,
                                          input logic [31:0] lo);
    logic [32:0] diff;
    diff = {1'b0, val} - {1'b0, step};
    if (diff[32] || (diff < {1'b0, lo})) begin
      return {1'b1, lo};
    end
    return diff;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pathfinder_search_sync2.sv
// ---------------------------------------------------------------------------
// sync2: two-flop synchroniser for asynchronous sensor levels.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pathfinder_search.sv
// ---------------------------------------------------------------------------
// pathfinder_search: hill-climbing frequency/amplitude search for the rocker.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pathfinder_search
  import pathfinder_pkg::*;
#(
  parameter int FREQ_W        = 8,
  parameter int AMP_W         = 8,
  parameter int FREQ_MIN      = 4,
  parameter int FREQ_MAX      = 250,
  parameter int FREQ_INIT     = 64,
  parameter int FREQ_STEP     = 2,
  parameter int AMP_MIN       = 8,
  parameter int AMP_MAX       = 240,
  parameter int AMP_INIT      = 128,
  parameter int AMP_STEP      = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int STRESS_LIMIT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              stress,
  output logic [FREQ_W-1:0] freq,
  output logic [AMP_W-1:0]  amp,
  output logic              dir_up,
  output logic              Fplus,
  output logic              Fmin,
  output logic              Aplus,
  output logic              Amin,
  output logic              busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SC_W  = $clog2(STRESS_LIMIT + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SC_W-1:0]  LIMIT_V     = SC_W'(STRESS_LIMIT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [AMP_W-1:0]   amp_q, amp_d;
  logic               dir_q, dir_d;
  logic               prev_q, prev_d;
  logic [SC_W-1:0]    scnt_q, scnt_d;
  logic               fplus_q, fplus_d, fmin_q, fmin_d;
  logic               aplus_q, aplus_d, amin_q, amin_d;
  logic               stress_s;

  logic [32:0]        w_freq_up, w_freq_dn, w_amp_up, w_amp_dn;
  logic [AMP_W-1:0]   w_amp_up_v, w_amp_dn_v;

  sync2 #(.WIDTH(1)) u_stress_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (stress),
    .q_o   (stress_s)
  );

  assign w_freq_up  = sat_add(32'(freq_q), 32'(FREQ_STEP), 32'(FREQ_MAX));
  assign w_freq_dn  = sat_sub(32'(freq_q), 32'(FREQ_STEP), 32'(FREQ_MIN));
  assign w_amp_up   = sat_add(32'(amp_q), 32'(AMP_STEP), 32'(AMP_MAX));
  assign w_amp_dn   = sat_sub(32'(amp_q), 32'(AMP_STEP), 32'(AMP_MIN));
  assign w_amp_up_v = AMP_W'(w_amp_up);
  assign w_amp_dn_v = AMP_W'(w_amp_dn);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    freq_d  = freq_q;
    amp_d   = amp_q;
    dir_d   = dir_q;
    prev_d  = prev_q;
    scnt_d  = scnt_q;
    fplus_d = 1'b0;
    fmin_d  = 1'b0;
    aplus_d = 1'b0;
    amin_d  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_d = ST_EVAL;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_EVAL: begin
          if (!stress_s) begin
            amp_d   = w_amp_dn_v;
            amin_d  = (w_amp_dn_v != amp_q);
            scnt_d  = '0;
            prev_d  = 1'b0;
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else begin
            // Stress on two evaluations in a row means the last step went the wrong way.
            if (prev_q) dir_d = ~dir_q;
            if ((scnt_q + SC_W'(1)) == LIMIT_V) begin
              amp_d   = w_amp_up_v;
              aplus_d = (w_amp_up_v != amp_q);
              scnt_d  = '0;
            end else begin
              scnt_d  = scnt_q + SC_W'(1);
            end
            prev_d  = 1'b1;
            state_d = ST_STEP;
          end
        end
        ST_STEP: begin
          if (dir_q) begin
            freq_d = FREQ_W'(w_freq_up);
            if (w_freq_up[32]) dir_d   = 1'b0;
            else               fplus_d = 1'b1;
          end else begin
            freq_d = FREQ_W'(w_freq_dn);
            if (w_freq_dn[32]) dir_d  = 1'b1;
            else               fmin_d = 1'b1;
          end
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      freq_q  <= FREQ_W'(FREQ_INIT);
      amp_q   <= AMP_W'(AMP_INIT);
      dir_q   <= 1'b1;
      prev_q  <= 1'b0;
      scnt_q  <= '0;
      fplus_q <= 1'b0;
      fmin_q  <= 1'b0;
      aplus_q <= 1'b0;
      amin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq_d;
      amp_q   <= amp_d;
      dir_q   <= dir_d;
      prev_q  <= prev_d;
      scnt_q  <= scnt_d;
      fplus_q <= fplus_d;
      fmin_q  <= fmin_d;
      aplus_q <= aplus_d;
      amin_q  <= amin_d;
    end
  end

  assign freq   = freq_q;
  assign amp    = amp_q;
  assign dir_up = dir_q;
  assign Fplus  = fplus_q;
  assign Fmin   = fmin_q;
  assign Aplus  = aplus_q;
  assign Amin   = amin_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pathfinder_search.sv
// ---------------------------------------------------------------------------
// tb_pathfinder_search: scoreboard bench with an evaluation-level reference model.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pathfinder_search;

  localparam int FMIN = 4, FMAX = 250, FINIT = 64, FSTEP = 2;
  localparam int AMIN = 8, AMAX = 240, AINIT = 128, ASTEP = 4;
  localparam int SETTLE = 4, LIMIT = 2;

  typedef logic [21:0] obs_t;

  logic       clk = 1'b0;
  logic       reset, enable, stress;
  logic [7:0] freq, amp;
  logic       dir_up, Fplus, Fmin, Aplus, Amin, busy;

  pathfinder_search #(
    .FREQ_W(8), .AMP_W(8),
    .FREQ_MIN(FMIN), .FREQ_MAX(FMAX), .FREQ_INIT(FINIT), .FREQ_STEP(FSTEP),
    .AMP_MIN(AMIN), .AMP_MAX(AMAX), .AMP_INIT(AINIT), .AMP_STEP(ASTEP),
    .SETTLE_CYCLES(SETTLE), .STRESS_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .stress(stress),
    .freq(freq), .amp(amp), .dir_up(dir_up),
    .Fplus(Fplus), .Fmin(Fmin), .Aplus(Aplus), .Amin(Amin), .busy(busy)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: setpoints as plain integers, timing as "edges until next evaluation".
  int   m_freq, m_amp, m_cnt, m_ete;
  bit   m_dir, m_prev, m_run, m_step, m_evald;
  bit   m_sa, m_sb;
  obs_t m_last = '1;

  function automatic obs_t pack(input int f, input int a, input bit d, input bit fp,
                                input bit fm, input bit ap, input bit am, input bit b);
    return {f[7:0], a[7:0], d, fp, fm, ap, am, b};
  endfunction

  task automatic model_push(input bit fp, input bit fm, input bit ap, input bit am);
    obs_t o;
    o = pack(m_freq, m_amp, m_dir, fp, fm, ap, am, m_run);
    if (o != m_last) begin
      exp_q.push_back(o);
      m_last = o;
    end
  endtask

  task automatic model_reset();
    m_freq = FINIT; m_amp = AINIT; m_dir = 1'b1; m_prev = 1'b0; m_cnt = 0;
    m_run = 1'b0; m_step = 1'b0; m_ete = 0; m_sa = 1'b0; m_sb = 1'b0; m_evald = 1'b0;
    model_push(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_edge(input bit en, input bit s_in);
    bit s_used, fp, fm, ap, am;
    int target, na;
    s_used = m_sb; m_sb = m_sa; m_sa = s_in;
    fp = 0; fm = 0; ap = 0; am = 0;
    m_evald = 1'b0;
    if (!en) begin
      m_run = 1'b0;
      m_step = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_ete = SETTLE + 1;
    end else if (m_step) begin
      m_step = 1'b0;
      m_ete = SETTLE + 1;
      target = m_dir ? m_freq + FSTEP : m_freq - FSTEP;
      if (target > FMAX || target < FMIN) begin
        m_freq = (target > FMAX) ? FMAX : FMIN;
        m_dir = !m_dir;
      end else begin
        m_freq = target;
        if (m_dir) fp = 1; else fm = 1;
      end
    end else begin
      m_ete = m_ete - 1;
      if (m_ete == 0) begin
        m_evald = 1'b1;
        m_ete = SETTLE + 1;
        if (!s_used) begin
          na = (m_amp - ASTEP < AMIN) ? AMIN : m_amp - ASTEP;
          am = (na != m_amp);
          m_amp = na; m_cnt = 0; m_prev = 1'b0;
        end else begin
          if (m_prev) m_dir = !m_dir;
          m_cnt = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1;
          if (m_cnt == LIMIT) begin
            na = (m_amp + ASTEP > AMAX) ? AMAX : m_amp + ASTEP;
            ap = (na != m_amp);
            m_amp = na; m_cnt = 0;
          end
          m_prev = 1'b1;
          m_step = 1'b1;
        end
      end
    end
    model_push(fp, fm, ap, am);
  endtask

  task automatic drive(input bit en, input bit st);
    enable = en;
    stress = st;
    model_edge(en, st);
  endtask

  task automatic cycle(input bit en, input bit st);
    @(negedge clk);
    #1;
    drive(en, st);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    drive(enable, stress);
  endtask

  // Monitor: every observable change of the DUT must match the next predicted change.
  initial begin
    obs_t last_obs, obs, e;
    last_obs = '1;
    forever begin
      @(negedge clk);
      obs = {freq, amp, dir_up, Fplus, Fmin, Aplus, Amin, busy};
      if (obs !== last_obs) begin
        last_obs = obs;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change actual=%h required=no_change", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            bad++;
            $display("FAIL event%0d actual=%h required=%h (freq,amp,dir,F+,F-,A+,A-,busy)",
                     total, obs, e);
          end
        end
      end
    end
  end

  initial begin
    bit alt, did_rst, rs, re;
    int hold;
    reset = 1'b0; enable = 1'b0; stress = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);

    // Calm: amplitude walks down to its floor, frequency untouched.
    for (int i = 0; i < 200; i++) cycle(1'b1, 1'b0);

    // Persistent stress: direction flips each evaluation, amplitude climbs to its ceiling.
    for (int i = 0; i < 900; i++) cycle(1'b1, 1'b1);

    // Alternate stress per evaluation: frequency marches to each limit and bounces.
    alt = 1'b1;
    for (int i = 0; i < 2700; i++) begin
      cycle(1'b1, alt);
      if (m_evald) alt = ~alt;
    end

    // Random enable/stress, with one reset landing in a step cycle.
    did_rst = 1'b0; hold = 0; rs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!did_rst && i > 1500 && m_step) begin
        do_reset();
        did_rst = 1'b1;
      end else begin
        if (hold == 0) begin
          rs = 1'($urandom_range(0, 1));
          hold = $urandom_range(1, 15);
        end
        hold--;
        re = ($urandom_range(0, 24) != 0);
        cycle(re, rs);
      end
    end

    repeat (3) cycle(1'b0, 1'b0);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
